// File: rtl/hilo_pkg.sv
// -----------------------------------------------------------------------------
// hilo_pkg
// Shared definitions for the HI/LO sequencer that sits behind the iterative
// divider.
//   state_t             : sequencer states IDLE / START / WAIT / COMMIT
//   DIV_LATENCY_DEFAULT : default number of WAIT cycles before the commit
//   CNT_W               : WAIT counter width (holds every legal latency 31..63)
//   DATA_W              : architectural register width
// -----------------------------------------------------------------------------
package hilo_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        WAIT   = 2'd2,
        COMMIT = 2'd3
    } state_t;

    localparam int DIV_LATENCY_DEFAULT = 32;
    localparam int CNT_W               = 6;
    localparam int DATA_W              = 32;

endpackage

// File: rtl/hilo_regs.sv
// -----------------------------------------------------------------------------
// hilo_regs
// Architectural HI/LO register pair with its write mux.
// Write priority: reset > divider commit > MTHI/MTLO.
// Ports:
//   clk       in   core clock
//   reset     in   synchronous, active-high; clears HI and LO
//   i_commit  in   load divider remainder/quotient into HI/LO
//   i_mtHi    in   write i_wrData into HI (already qualified by the sequencer)
//   i_mtLo    in   write i_wrData into LO (already qualified by the sequencer)
//   i_wrData  in   MTHI/MTLO source data
//   i_divHi   in   divider remainder
//   i_divLo   in   divider quotient
//   o_hi      out  architectural HI
//   o_lo      out  architectural LO
// -----------------------------------------------------------------------------
module hilo_regs
    import hilo_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_commit,
    input  logic              i_mtHi,
    input  logic              i_mtLo,
    input  logic [DATA_W-1:0] i_wrData,
    input  logic [DATA_W-1:0] i_divHi,
    input  logic [DATA_W-1:0] i_divLo,
    output logic [DATA_W-1:0] o_hi,
    output logic [DATA_W-1:0] o_lo
);

    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (i_commit) begin
            r_hi <= i_divHi;
            r_lo <= i_divLo;
        end else begin
            if (i_mtHi) r_hi <= i_wrData;
            if (i_mtLo) r_lo <= i_wrData;
        end
    end

    assign o_hi = r_hi;
    assign o_lo = r_lo;

endmodule

// File: rtl/hilo_ctrl.sv
// -----------------------------------------------------------------------------
// hilo_ctrl
// Divide sequencer plus HI/LO registers. Launches the iterative divider with a
// one-cycle start pulse, waits DIV_LATENCY cycles, then commits the divider's
// remainder/quotient into HI/LO. Serves MTHI/MTLO in IDLE and stalls the
// control unit while a divide is in flight.
//
// Build option: macro DIVZERO_EXC_EN
//   defined   : divZero (active-low) checked in the first WAIT cycle; a zero
//               divisor aborts the divide and pulses divZeroExc
//   undefined : divZero ignored, every divide commits, divZeroExc tied low
//
// Parameter: DIV_LATENCY  WAIT cycles before commit, legal 31..63
// Ports:
//   clk         in   core clock
//   reset       in   synchronous, active-high
//   divReq      in   DIV request, sampled only in IDLE
//   mtHi/mtLo   in   MTHI/MTLO requests (honoured only in IDLE)
//   rdReq       in   MFHI/MFLO in decode, stall generation only
//   wrData      in   MTHI/MTLO source data
//   divHi       in   divider remainder
//   divLo       in   divider quotient
//   divZero     in   divider flag, 0 = divide-by-zero
//   divCtrl     out  registered one-cycle divider start pulse
//   hiOut/loOut out  architectural HI/LO
//   busy        out  divide in flight (START/WAIT/COMMIT), combinational
//   stall       out  busy & any HI/LO-related request, combinational
//   divDone     out  one-cycle pulse, new HI/LO visible
//   divZeroExc  out  one-cycle pulse, divide aborted
// -----------------------------------------------------------------------------
module hilo_ctrl
    import hilo_pkg::*;
#(
    parameter int DIV_LATENCY = DIV_LATENCY_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              divReq,
    input  logic              mtHi,
    input  logic              mtLo,
    input  logic              rdReq,
    input  logic [DATA_W-1:0] wrData,
    input  logic [DATA_W-1:0] divHi,
    input  logic [DATA_W-1:0] divLo,
    input  logic              divZero,
    output logic              divCtrl,
    output logic [DATA_W-1:0] hiOut,
    output logic [DATA_W-1:0] loOut,
    output logic              busy,
    output logic              stall,
    output logic              divDone,
    output logic              divZeroExc
);

    // Counter value on the last WAIT cycle; the counter starts at 0.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_LATENCY - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;

    logic w_idle;
    logic w_busy;
    logic w_launch;
    logic w_commit;
    logic w_abort;
    logic w_mtHi;
    logic w_mtLo;

    logic r_divCtrl;
    logic r_divDone;
    logic r_divZeroExc;

`ifdef DIVZERO_EXC_EN
    // divZero becomes valid one edge after the start pulse, i.e. in WAIT cycle 0.
    assign w_abort = (r_state == WAIT) && (r_cnt == '0) && !divZero;
`else
    logic w_unused_divZero;
    assign w_unused_divZero = divZero;
    assign w_abort          = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // WAIT counter: cleared in START, counts every WAIT cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_state == START) begin
            r_cnt <= '0;
        end else if (r_state == WAIT) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (divReq) w_next = START;
            START:   w_next = WAIT;
            WAIT: begin
                if (w_abort)               w_next = IDLE;
                else if (r_cnt == CNT_LAST) w_next = COMMIT;
            end
            COMMIT:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Output decode; requests arriving while busy are dropped, not queued
    always_comb begin
        w_idle   = (r_state == IDLE);
        w_busy   = !w_idle;
        w_launch = w_idle && divReq;
        w_commit = (r_state == COMMIT);
        w_mtHi   = w_idle && mtHi;
        w_mtLo   = w_idle && mtLo;
    end

    // Registered pulses: start pulse lands in START, done/exception one cycle
    // after COMMIT/abort so they coincide with the updated state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_divCtrl    <= 1'b0;
            r_divDone    <= 1'b0;
            r_divZeroExc <= 1'b0;
        end else begin
            r_divCtrl    <= w_launch;
            r_divDone    <= w_commit;
            r_divZeroExc <= w_abort;
        end
    end

    hilo_regs u_regs (
        .clk      (clk),
        .reset    (reset),
        .i_commit (w_commit),
        .i_mtHi   (w_mtHi),
        .i_mtLo   (w_mtLo),
        .i_wrData (wrData),
        .i_divHi  (divHi),
        .i_divLo  (divLo),
        .o_hi     (hiOut),
        .o_lo     (loOut)
    );

    assign divCtrl    = r_divCtrl;
    assign divDone    = r_divDone;
    assign divZeroExc = r_divZeroExc;
    assign busy       = w_busy;
    assign stall      = w_busy && (divReq || mtHi || mtLo || rdReq);

endmodule

// File: tb/tb_hilo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hilo_ctrl
// Directed bench for hilo_ctrl with a behavioural divider. Expected HI/LO pairs
// are queued when a divide is requested and checked when divDone pulses.
// -----------------------------------------------------------------------------
module tb_hilo_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        divReq, mtHi, mtLo, rdReq;
    logic [31:0] wrData;
    logic [31:0] divHi, divLo;
    logic        divZero;
    logic        divCtrl, busy, stall, divDone, divZeroExc;
    logic [31:0] hiOut, loOut;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;
    exp_t sb[$];

    int signed srcA, srcB;

    always #5 clk = ~clk;

    hilo_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .divReq     (divReq),
        .mtHi       (mtHi),
        .mtLo       (mtLo),
        .rdReq      (rdReq),
        .wrData     (wrData),
        .divHi      (divHi),
        .divLo      (divLo),
        .divZero    (divZero),
        .divCtrl    (divCtrl),
        .hiOut      (hiOut),
        .loOut      (loOut),
        .busy       (busy),
        .stall      (stall),
        .divDone    (divDone),
        .divZeroExc (divZeroExc)
    );

    // Behavioural divider: samples operands on the start pulse, results and
    // divZero flag stable from the following edge onwards.
    always @(posedge clk) begin
        if (divCtrl) begin
            if (srcB == 0) begin
                divHi   <= srcA;
                divLo   <= 32'hFFFF_FFFF;
                divZero <= 1'b0;
            end else begin
                divHi   <= srcA % srcB;
                divLo   <= srcA / srcB;
                divZero <= 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sb_check(input string tag);
        exp_t e;
        if (divDone === 1'b1 && sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_hi"}, hiOut, e.hi);
            chk({tag, "_lo"}, loOut, e.lo);
        end else begin
            chk({tag, "_done_seen"}, {31'd0, divDone}, 32'd1);
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (divDone !== 1'b1 && n < 100) begin
            step();
            n++;
        end
    endtask

    // Full divide from request to commit with latency/busy/exception checks.
    task automatic run_div(input string tag, input int a, input int b,
                           input logic [31:0] eh, input logic [31:0] el);
        int n, nbusy, nexc;
        srcA = a;
        srcB = b;
        sb.push_back('{hi: eh, lo: el});
        divReq = 1'b1;
        step();                                   // E0
        divReq = 1'b0;
        chk({tag, "_divCtrl_E0"}, {31'd0, divCtrl}, 32'd1);
        nbusy = (busy === 1'b1) ? 1 : 0;
        nexc  = 0;
        step();                                   // E1
        chk({tag, "_divCtrl_E1"}, {31'd0, divCtrl}, 32'd0);
        n = 1;
        nbusy += (busy === 1'b1) ? 1 : 0;
        while (divDone !== 1'b1 && n < 100) begin
            step();
            n++;
            nbusy += (busy === 1'b1) ? 1 : 0;
            nexc  += (divZeroExc === 1'b1) ? 1 : 0;
        end
        chk({tag, "_latency"}, n, 34);
        chk({tag, "_busy_cycles"}, nbusy, 34);
        chk({tag, "_no_exc"}, nexc, 0);
        sb_check(tag);
        step();
        chk({tag, "_done_1cyc"}, {31'd0, divDone}, 32'd0);
    endtask

    initial begin
        int n, cnt;
        reset   = 1'b1;
        divReq  = 1'b0;
        mtHi    = 1'b0;
        mtLo    = 1'b0;
        rdReq   = 1'b0;
        wrData  = '0;
        divHi   = '0;
        divLo   = '0;
        divZero = 1'b1;
        srcA    = 0;
        srcB    = 1;
        repeat (3) step();
        reset = 1'b0;
        rdReq = 1'b1;
        #1;
        chk("rst_hi", hiOut, 32'd0);
        chk("rst_lo", loOut, 32'd0);
        chk("rst_divCtrl", {31'd0, divCtrl}, 32'd0);
        chk("rst_divDone", {31'd0, divDone}, 32'd0);
        chk("rst_exc", {31'd0, divZeroExc}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_stall_idle", {31'd0, stall}, 32'd0);
        rdReq = 1'b0;
        step();

        // Basic divides
        run_div("d100_7", 100, 7, 32'd2, 32'd14);
        run_div("dm7_2", -7, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        // Preload HI/LO, then divide by zero
        mtHi = 1'b1; wrData = 32'hAAAA_0000;
        step();
        mtHi = 1'b0; mtLo = 1'b1; wrData = 32'h0000_5555;
        step();
        mtLo = 1'b0;
        chk("mt_hi", hiOut, 32'hAAAA_0000);
        chk("mt_lo", loOut, 32'h0000_5555);
`ifdef DIVZERO_EXC_EN
        srcA = 50; srcB = 0;
        divReq = 1'b1;
        step();                                   // E0
        divReq = 1'b0;
        chk("dz_divCtrl", {31'd0, divCtrl}, 32'd1);
        step();                                   // E1
        chk("dz_busy_E1", {31'd0, busy}, 32'd1);
        chk("dz_exc_E1", {31'd0, divZeroExc}, 32'd0);
        step();                                   // E2
        chk("dz_busy_E2", {31'd0, busy}, 32'd0);
        chk("dz_exc_E2", {31'd0, divZeroExc}, 32'd1);
        chk("dz_hi", hiOut, 32'hAAAA_0000);
        chk("dz_lo", loOut, 32'h0000_5555);
        step();
        chk("dz_exc_1cyc", {31'd0, divZeroExc}, 32'd0);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            cnt += (divDone === 1'b1) ? 1 : 0;
            step();
        end
        chk("dz_no_done", cnt, 0);
        chk("dz_hi_late", hiOut, 32'hAAAA_0000);
`else
        run_div("dz_commit", 50, 0, 32'd50, 32'hFFFF_FFFF);
`endif

        // Stall and ignored MTLO during WAIT
        srcA = 1000; srcB = 3;
        sb.push_back('{hi: 32'd1, lo: 32'd333});
        divReq = 1'b1;
        step();                                   // E0
        divReq = 1'b0;
        repeat (10) step();
        rdReq = 1'b1; mtLo = 1'b1; wrData = 32'h0000_1234;
        #1;
        chk("st_stall_wait", {31'd0, stall}, 32'd1);
        cnt = 0; n = 0;
        while (busy === 1'b1 && n < 100) begin
            step();
            n++;
            if (busy === 1'b1 && stall !== 1'b1) cnt++;
        end
        chk("st_stall_held", cnt, 0);
        chk("st_stall_idle", {31'd0, stall}, 32'd0);
        sb_check("st");
        rdReq = 1'b0; mtLo = 1'b0;
        step();
        chk("st_lo_after", loOut, 32'd333);

        // Reset in the middle of WAIT
        srcA = 81; srcB = 9;
        divReq = 1'b1;
        step();                                   // E0
        divReq = 1'b0;
        repeat (11) step();                       // WAIT cycle 10
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("rs_busy", {31'd0, busy}, 32'd0);
        chk("rs_hi", hiOut, 32'd0);
        chk("rs_lo", loOut, 32'd0);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            cnt += (divDone === 1'b1 || divZeroExc === 1'b1) ? 1 : 0;
        end
        chk("rs_no_pulses", cnt, 0);

        // Simultaneous MTHI and DIV, then back-to-back divide on divDone
        srcA = 77; srcB = 10;
        sb.push_back('{hi: 32'd7, lo: 32'd7});
        divReq = 1'b1; mtHi = 1'b1; wrData = 32'h0000_DEAD;
        step();                                   // E0
        divReq = 1'b0; mtHi = 1'b0;
        chk("sm_hi_dead", hiOut, 32'h0000_DEAD);
        chk("sm_busy", {31'd0, busy}, 32'd1);
        wait_done(n);
        chk("sm_latency", n, 34);
        sb_check("sm");
        srcA = 20; srcB = 6;
        sb.push_back('{hi: 32'd2, lo: 32'd3});
        divReq = 1'b1;
        step();
        divReq = 1'b0;
        chk("b2b_divCtrl", {31'd0, divCtrl}, 32'd1);
        wait_done(n);
        chk("b2b_latency", n, 34);
        sb_check("b2b");
        step();
        chk("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hilo_ctrl.md
# hilo_ctrl

Sequencer and architectural HI/LO register pair sitting directly downstream of the iterative divider in the multicycle CPU. Launches a divide with a one-cycle start pulse and waits out the fixed divider latency. Commits the divider's remainder/quotient into HI/LO, or aborts on divide-by-zero. Serves MFHI/MFLO/MTHI/MTLO and stalls the control unit while a divide is in flight.

## Interface
- DIV_LATENCY, 32, number of WAIT cycles before commit; legal range 31..63
- clk  in  1  core clock, all state on rising edge
- reset  in  1  synchronous, active-high
- divReq  in  1  control unit requests DIV; sampled only in IDLE
- mtHi  in  1  MTHI request; writes wrData into HI
- mtLo  in  1  MTLO request; writes wrData into LO
- rdReq  in  1  MFHI/MFLO in decode; used only for stall generation
- wrData  in  32  source data for MTHI/MTLO
- divHi  in  32  divider remainder output
- divLo  in  32  divider quotient output
- divZero  in  1  divider flag, active-low: 0 = divide-by-zero detected
- divCtrl  out  1  registered one-cycle start pulse to divider
- hiOut  out  32  architectural HI
- loOut  out  32  architectural LO
- busy  out  1  divide in flight (START, WAIT, COMMIT)
- stall  out  1  busy & (divReq | mtHi | mtLo | rdReq)
- divDone  out  1  one-cycle pulse, new HI/LO valid
- divZeroExc  out  1  one-cycle pulse, divide aborted

## Operation
- States: IDLE, START, WAIT, COMMIT.
- IDLE: divReq=1 -> START. mtHi/mtLo write hiOut/loOut at the edge.
- IDLE, simultaneous mt* and divReq: mt write applied; divide starts the same edge.
- START: divCtrl=1 for exactly this cycle; -> WAIT, counter cleared to 0.
- WAIT: counter increments each cycle; -> COMMIT after DIV_LATENCY cycles.
- WAIT, first cycle: divZero=0 -> IDLE. divZeroExc pulses. HI/LO unchanged.
- COMMIT: hiOut<=divHi, loOut<=divLo; divDone pulses next cycle; -> IDLE.
- While busy: divReq/mtHi/mtLo ignored, not queued. Control unit holds them under stall.
- No signed handling here. The divider delivers two's-complement results.
- Counter width: 6 bits, no wrap within legal DIV_LATENCY.

## Timing
- Reset values: hiOut=0, loOut=0, divCtrl=0, divDone=0, divZeroExc=0, busy=0, stall=0; state IDLE.
- divReq sampled at edge E0 -> divCtrl high during cycle E0..E1.
- Divider samples at E1; divZero is valid from E1.
- WAIT spans E1..E(1+DIV_LATENCY).
- COMMIT writes HI/LO at E(2+DIV_LATENCY).
- divDone high in the following cycle. Default total: 34 edges from divReq to visible result.
- divZeroExc high in the cycle after E2; busy low from E2.
- busy and stall are combinational from state and inputs, with no register delay.
- Reset mid-operation: immediate return to IDLE, HI/LO cleared. No divDone or divZeroExc is emitted. The divider shares the same reset.
- A new divReq is accepted in the cycle divDone is high (state already IDLE).

## Configuration
- DIVZERO_EXC_EN defined: divZero checked in the first WAIT cycle; abort plus divZeroExc as above.
- DIVZERO_EXC_EN undefined: divZero ignored; every divide commits divHi/divLo; divZeroExc tied 0.

## Structure
- Package hilo_pkg: state enum typedef (IDLE, START, WAIT, COMMIT), DIV_LATENCY_DEFAULT=32, counter width constant.
- Sub-module hilo_regs: HI/LO register pair with write mux (reset > commit > mt*). Sequencer FSM and counter stay in hilo_ctrl.

## Test plan
- srcA=100, srcB=7, divReq pulse -> divCtrl one cycle; hiOut=2, loOut=14, divDone 34 cycles after divReq.
- srcA=-7, srcB=2 -> hiOut=0xFFFFFFFF, loOut=0xFFFFFFFD; busy high for exactly 34 cycles.
- Preload mtHi=0xAAAA0000, mtLo=0x5555; srcB=0 -> divZeroExc pulse after E2, HI/LO unchanged, no divDone. With the macro off: commit occurs, divZeroExc stays 0.
- rdReq and mtLo (wrData=0x1234) asserted mid-WAIT -> stall high until IDLE; loOut ends as the divide result, not 0x1234.
- Reset asserted at WAIT cycle 10 -> next cycle IDLE, hiOut=loOut=0, busy=0, no pulses.
- divReq and mtHi (wrData=0xDEAD) in the same IDLE cycle -> hiOut=0xDEAD next cycle, later overwritten by the divide remainder.
